// File: rtl/pipe_reg_skid.sv
// Pipeline stage register with valid/ready handshake, one-entry skid buffer and synchronous flush.
// Optional saturating stall counter enabled by defining PIPE_REG_STALL_CNT_EN.
module pipe_reg_skid #(
  parameter int unsigned          WIDTH     = 32,
  parameter logic [WIDTH-1:0]     RESET_VAL = '0
`ifdef PIPE_REG_STALL_CNT_EN
  ,
  parameter int unsigned          CNT_W     = 16
`endif
) (
  input  logic             clk,
  input  logic             clrn,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
`ifdef PIPE_REG_STALL_CNT_EN
  output logic [CNT_W-1:0] stall_cnt,
`endif
  output logic [1:0]       occupancy
);

  logic             main_v;
  logic             skid_v;
  logic [WIDTH-1:0] main_d;
  logic [WIDTH-1:0] skid_d;
  logic             in_fire;
  logic             out_fire;

  assign in_fire  = in_valid & ~skid_v;
  assign out_fire = main_v & out_ready;

  // Outputs come straight from the storage registers; no input reaches an output combinationally.
  assign out_valid = main_v;
  assign out_data  = main_d;
  assign in_ready  = ~skid_v;
  assign occupancy = 2'({1'b0, main_v} + {1'b0, skid_v});

  // State is (main_v, skid_v): EMPTY (0,0), ONE (1,0), FULL (1,1).
  always_ff @(posedge clk) begin
    if (!clrn) begin
      main_v <= 1'b0;
      skid_v <= 1'b0;
      main_d <= RESET_VAL;
      skid_d <= RESET_VAL;
    end else if (flush) begin
      main_v <= 1'b0;
      skid_v <= 1'b0;
    end else begin
      case ({main_v, skid_v})
        2'b00: begin
          if (in_fire) begin
            main_d <= in_data;
            main_v <= 1'b1;
          end
        end
        2'b10: begin
          if (in_fire && out_fire) begin
            main_d <= in_data;
          end else if (in_fire) begin
            skid_d <= in_data;
            skid_v <= 1'b1;
          end else if (out_fire) begin
            main_v <= 1'b0;
          end
        end
        2'b11: begin
          if (out_fire) begin
            main_d <= skid_d;
            skid_v <= 1'b0;
          end
        end
        default: begin
          // Unreachable (0,1): recover to EMPTY.
          main_v <= 1'b0;
          skid_v <= 1'b0;
        end
      endcase
    end
  end

`ifdef PIPE_REG_STALL_CNT_EN
  // Counts cycles where a payload is offered but not taken; flush leaves it intact.
  always_ff @(posedge clk) begin
    if (!clrn) begin
      stall_cnt <= '0;
    end else if (main_v && !out_ready && (stall_cnt != {CNT_W{1'b1}})) begin
      stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_pipe_reg_skid.sv
// Directed self-checking bench for pipe_reg_skid; define PIPE_REG_STALL_CNT_EN to cover the stall counter.
module tb_pipe_reg_skid;

  localparam int unsigned WIDTH = 32;

  logic             clk;
  logic             clrn;
  logic             flush;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic [1:0]       occupancy;
`ifdef PIPE_REG_STALL_CNT_EN
  logic [1:0]       stall_cnt;
`endif

  int checks = 0;
  int errors = 0;

  pipe_reg_skid #(
    .WIDTH(WIDTH),
    .RESET_VAL('0)
`ifdef PIPE_REG_STALL_CNT_EN
    ,
    .CNT_W(2)
`endif
  ) dut (
    .clk(clk),
    .clrn(clrn),
    .flush(flush),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_data(in_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data(out_data),
`ifdef PIPE_REG_STALL_CNT_EN
    .stall_cnt(stall_cnt),
`endif
    .occupancy(occupancy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_state(input string tag, input logic v, input logic rdy, input logic [1:0] occ);
    chk({tag, "_valid"}, 32'(out_valid), 32'(v));
    chk({tag, "_ready"}, 32'(in_ready), 32'(rdy));
    chk({tag, "_occ"}, 32'(occupancy), 32'(occ));
  endtask

  initial begin
    clrn      = 1'b0;
    flush     = 1'b0;
    in_valid  = 1'b1;
    in_data   = 32'hDEAD_BEEF;
    out_ready = 1'b0;

    // Reset held two cycles with a valid input present
    tick();
    tick();
    chk_state("rst", 1'b0, 1'b1, 2'd0);
    chk("rst_data", out_data, 32'h0);

    // Streaming at full throughput
    clrn = 1'b1; out_ready = 1'b1; in_valid = 1'b1; in_data = 32'h1;
    tick();
    chk_state("s1", 1'b1, 1'b1, 2'd1);
    chk("s1_data", out_data, 32'h1);
    in_data = 32'h2;
    tick();
    chk_state("s2", 1'b1, 1'b1, 2'd1);
    chk("s2_data", out_data, 32'h2);
    in_data = 32'h3;
    tick();
    chk_state("s3", 1'b1, 1'b1, 2'd1);
    chk("s3_data", out_data, 32'h3);
    in_valid = 1'b0;
    tick();
    chk_state("s_drain", 1'b0, 1'b1, 2'd0);

    // Back-pressure fills skid, C is refused until space frees up
    out_ready = 1'b0; in_valid = 1'b1; in_data = 32'hA;
    tick();
    chk_state("bp_a", 1'b1, 1'b1, 2'd1);
    chk("bp_a_data", out_data, 32'hA);
    in_data = 32'hB;
    tick();
    chk_state("bp_b", 1'b1, 1'b0, 2'd2);
    chk("bp_b_data", out_data, 32'hA);
    in_data = 32'hC;
    tick();
    chk_state("bp_c_held", 1'b1, 1'b0, 2'd2);
    chk("bp_c_data", out_data, 32'hA);
    out_ready = 1'b1;
    tick();
    chk_state("bp_rel1", 1'b1, 1'b1, 2'd1);
    chk("bp_rel1_data", out_data, 32'hB);
    tick();
    chk_state("bp_rel2", 1'b1, 1'b1, 2'd1);
    chk("bp_rel2_data", out_data, 32'hC);
    in_valid = 1'b0;
    tick();
    chk_state("bp_drain", 1'b0, 1'b1, 2'd0);

    // Flush while FULL discards held entries and the same-cycle input
    out_ready = 1'b0; in_valid = 1'b1; in_data = 32'hA;
    tick();
    in_data = 32'hB;
    tick();
    chk_state("fl_full", 1'b1, 1'b0, 2'd2);
    flush = 1'b1; in_data = 32'hF;
    tick();
    chk_state("fl", 1'b0, 1'b1, 2'd0);
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    tick();
    chk_state("fl_after", 1'b0, 1'b1, 2'd0);

    // Reset mid-stream at occupancy 2
    out_ready = 1'b0; in_valid = 1'b1; in_data = 32'h7;
    tick();
    in_data = 32'h8;
    tick();
    chk_state("mr_full", 1'b1, 1'b0, 2'd2);
    clrn = 1'b0; in_valid = 1'b0;
    tick();
    chk_state("mr_rst", 1'b0, 1'b1, 2'd0);
    chk("mr_rst_data", out_data, 32'h0);
    clrn = 1'b1; in_valid = 1'b1; in_data = 32'h5; out_ready = 1'b1;
    tick();
    chk_state("mr_5", 1'b1, 1'b1, 2'd1);
    chk("mr_5_data", out_data, 32'h5);
    in_valid = 1'b0;
    tick();
    chk_state("mr_drain", 1'b0, 1'b1, 2'd0);

`ifdef PIPE_REG_STALL_CNT_EN
    // Stall counter saturates at 3, survives flush, cleared by reset
    clrn = 1'b0;
    tick();
    chk("sc_rst", 32'(stall_cnt), 32'd0);
    clrn = 1'b1; in_valid = 1'b1; in_data = 32'h9; out_ready = 1'b0;
    tick();
    chk("sc_load", 32'(stall_cnt), 32'd0);
    in_valid = 1'b0;
    tick();
    chk("sc_1", 32'(stall_cnt), 32'd1);
    tick();
    chk("sc_2", 32'(stall_cnt), 32'd2);
    tick();
    chk("sc_3", 32'(stall_cnt), 32'd3);
    tick();
    chk("sc_4", 32'(stall_cnt), 32'd3);
    tick();
    chk("sc_5", 32'(stall_cnt), 32'd3);
    flush = 1'b1;
    tick();
    chk("sc_flush", 32'(stall_cnt), 32'd3);
    chk_state("sc_flush", 1'b0, 1'b1, 2'd0);
    flush = 1'b0; clrn = 1'b0;
    tick();
    chk("sc_clr", 32'(stall_cnt), 32'd0);
    clrn = 1'b1;
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipe_reg_skid.md
Name: pipe_reg_skid

Overview:
Parametrised pipeline stage register, the successor to the plain 32-bit D register used between datapath stages. It adds a valid/ready handshake, a one-entry skid buffer for full throughput under back-pressure, and a synchronous flush. It is the common building block for every stage boundary of the pipelined CPU, e.g. IF/ID and ID/EX, where stalls and branch flushes occur.

Parameters:
WIDTH, 32, payload width in bits (1..256)
RESET_VAL, 0, value loaded into both data registers on reset (WIDTH bits)
CNT_W, 16, width of stall counter (optional feature only)

Ports:
clk  input  1  rising-edge clock
clrn  input  1  synchronous active-low reset
flush  input  1  synchronous flush; discards all held entries
in_valid  input  1  upstream payload valid
in_ready  output  1  stage can accept a payload this cycle
in_data  input  WIDTH  upstream payload
out_valid  output  1  payload available downstream
out_ready  input  1  downstream accepts the payload this cycle
out_data  output  WIDTH  payload to downstream
occupancy  output  2  number of held entries: 0, 1 or 2

Behaviour:
- Single clock domain. Every state change happens on the rising edge of clk.
- Storage: main register (main_v, main_d) and skid register (skid_v, skid_d).
- Outputs: out_valid = main_v, out_data = main_d, in_ready = !skid_v, occupancy = main_v + skid_v. All outputs are driven only from registers, with no combinational in-to-out path.
- Handshakes: in_fire = in_valid & in_ready; out_fire = out_valid & out_ready.
- in_data and in_valid are ignored when in_ready = 0. out_data is don't-care when out_valid = 0.
- Reset: clrn = 0 at a clock edge clears main_v and skid_v and loads main_d = skid_d = RESET_VAL. Reset takes priority over everything. After reset: out_valid 0, in_ready 1, occupancy 0.
- Reset mid-operation drops all held entries. No output is produced from them.
- Priority order: reset > flush > normal operation.
- Flush (clrn = 1, flush = 1):
  - Clears main_v and skid_v; data registers hold their values.
  - Any in_fire in the same cycle is discarded.
  - An out_fire in the same cycle counts as consumed by downstream.
- States are encoded by (main_v, skid_v):
  - EMPTY (0,0): in_fire -> main_d <= in_data, go to ONE. Otherwise stay.
  - ONE (1,0):
    - in_fire & out_fire -> main_d <= in_data, stay ONE.
    - in_fire only -> skid_d <= in_data, go to FULL.
    - out_fire only -> go to EMPTY.
    - Neither -> hold.
  - FULL (1,1): in_ready = 0.
    - out_fire -> main_d <= skid_d, go to ONE.
    - Otherwise hold.
  - State (0,1) is illegal and unreachable.
- Latency: 1 cycle from in_fire into EMPTY to out_valid = 1.
- Throughput: 1 payload per cycle while out_ready = 1.
- Ordering: strict FIFO. No payload is lost or duplicated outside of flush and reset.
- Back-pressure: in_ready falls one cycle after the first stalled accept, which is when the skid register is used. It rises the cycle after out_fire from FULL.

Optional Feature:
Macro PIPE_REG_STALL_CNT_EN.
- Defined:
  - Adds output port stall_cnt (CNT_W bits).
  - It increments on every cycle with out_valid = 1 and out_ready = 0, and saturates at all-ones.
  - Cleared to 0 by reset only; flush does not clear it.
- Undefined: the port and counter logic are absent, and all other behaviour is identical.

Test Plan:
1. Reset: hold clrn = 0 for 2 cycles with in_valid = 1, in_data = 32'hDEAD_BEEF -> out_valid 0, in_ready 1, occupancy 0, out_data = RESET_VAL (0).
2. Streaming: out_ready = 1, send 0x1, 0x2, 0x3 on consecutive cycles -> out_data 0x1, 0x2, 0x3 on the next three cycles; in_ready stays 1; occupancy stays 1.
3. Back-pressure: out_ready = 0, send 0xA then 0xB -> occupancy 2 and in_ready 0; 0xC held on in_data is not accepted. Then out_ready = 1 -> outputs 0xA, then 0xB, then 0xC in order.
4. Flush while FULL (0xA, 0xB held) with in_valid = 1, in_data = 0xF -> next cycle out_valid 0, occupancy 0, in_ready 1; 0xF is never output.
5. Reset mid-stream at occupancy 2 -> next cycle occupancy 0. Sending 0x5 afterwards yields out_data 0x5 one cycle later.
6. PIPE_REG_STALL_CNT_EN with CNT_W = 2: stall for 5 cycles with out_valid = 1 -> stall_cnt reads 1, 2, 3, 3, 3. A flush leaves it at 3. clrn = 0 sets it to 0.
